// File: rtl/swbox_pkg.sv
// Shared definitions for the serially configured switch box: side codes, FSM states
// and the route-word validity rule.
package swbox_pkg;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A word routes only if it names a real side and its index fits that side.
  function automatic logic word_valid(input logic [2:0] side, input int idx,
                                      input int ntb, input int nlr);
    logic v;
    case (side)
      SIDE_TOP, SIDE_BOTTOM: v = (idx < ntb);
      SIDE_RIGHT, SIDE_LEFT: v = (idx < nlr);
      default:               v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/switch_box_cfg_if.sv
// Serial configuration port of the switch box. cfg_dout exists only when
// SWBOX_READBACK_EN is defined.
interface switch_box_cfg_if;
  logic cfg_en;
  logic cfg_din;
  logic cfg_commit;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;
  logic bad_cfg;
`ifdef SWBOX_READBACK_EN
  logic cfg_dout;

  modport master (output cfg_en, cfg_din, cfg_commit,
                  input  cfg_busy, cfg_done, cfg_err, bad_cfg, cfg_dout);
  modport slave  (input  cfg_en, cfg_din, cfg_commit,
                  output cfg_busy, cfg_done, cfg_err, bad_cfg, cfg_dout);
`else
  modport master (output cfg_en, cfg_din, cfg_commit,
                  input  cfg_busy, cfg_done, cfg_err, bad_cfg);
  modport slave  (input  cfg_en, cfg_din, cfg_commit,
                  output cfg_busy, cfg_done, cfg_err, bad_cfg);
`endif
endinterface

// File: rtl/swbox_pin_mux.sv
// One output pin of the switch box: decodes a {idx, side} word and selects the
// source input bit, reporting whether the word is unusable.
module swbox_pin_mux
  import swbox_pkg::*;
#(
  parameter int NTB  = 5,
  parameter int NLR  = 4,
  parameter int IDXW = 3
) (
  input  logic [IDXW+2:0] i_word,
  input  logic [NTB-1:0]  i_top,
  input  logic [NTB-1:0]  i_bottom,
  input  logic [NLR-1:0]  i_left,
  input  logic [NLR-1:0]  i_right,
  output logic            o_out,
  output logic            o_oe,
  output logic            o_invalid
);

  logic [2:0]      w_side;
  logic [IDXW-1:0] w_idx;
  logic            w_valid;
  logic            w_bit;
  logic [NTB-1:0]  w_top_sh;
  logic [NTB-1:0]  w_bottom_sh;
  logic [NLR-1:0]  w_left_sh;
  logic [NLR-1:0]  w_right_sh;

  assign w_side  = i_word[2:0];
  assign w_idx   = i_word[IDXW+2:3];
  assign w_valid = word_valid(w_side, int'(w_idx), NTB, NLR);

  // Shifting instead of indexing keeps an out-of-range idx harmless; it is masked anyway.
  assign w_top_sh    = i_top    >> w_idx;
  assign w_bottom_sh = i_bottom >> w_idx;
  assign w_left_sh   = i_left   >> w_idx;
  assign w_right_sh  = i_right  >> w_idx;

  always_comb begin
    w_bit = 1'b0;
    case (w_side)
      SIDE_TOP:    w_bit = w_top_sh[0];
      SIDE_RIGHT:  w_bit = w_right_sh[0];
      SIDE_BOTTOM: w_bit = w_bottom_sh[0];
      SIDE_LEFT:   w_bit = w_left_sh[0];
      default:     w_bit = 1'b0;
    endcase
  end

  assign o_out     = w_valid & w_bit;
  assign o_oe      = w_valid;
  assign o_invalid = (w_side != SIDE_NONE) & ~w_valid;

endmodule

// File: rtl/switch_box_cfg.sv
// Serially configured routing switch box: shift chain into a shadow image, atomic
// commit to the active image, per-pin muxes. Optional readback via SWBOX_READBACK_EN.
module switch_box_cfg
  import swbox_pkg::*;
#(
  parameter int NTB  = 5,
  parameter int NLR  = 4,
  parameter int IDXW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTB-1:0]    top_in,
  input  logic [NTB-1:0]    bottom_in,
  input  logic [NLR-1:0]    left_in,
  input  logic [NLR-1:0]    right_in,
  output logic [NTB-1:0]    top_out,
  output logic [NTB-1:0]    top_oe,
  output logic [NTB-1:0]    bottom_out,
  output logic [NTB-1:0]    bottom_oe,
  output logic [NLR-1:0]    left_out,
  output logic [NLR-1:0]    left_oe,
  output logic [NLR-1:0]    right_out,
  output logic [NLR-1:0]    right_oe,
  switch_box_cfg_if.slave   cfg
);

  localparam int NPIN = 2 * NTB + 2 * NLR;
  localparam int WW   = 3 + IDXW;
  localparam int L    = NPIN * WW;
  localparam int CNTW = $clog2(L + 2);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(L);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(L + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [L-1:0]    r_shadow;
  logic [L-1:0]    r_active;
  logic [CNTW-1:0] r_cnt;
  logic            r_err;
  logic            r_done;
  logic [NPIN-1:0] w_out;
  logic [NPIN-1:0] w_oe;
  logic [NPIN-1:0] w_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg.cfg_commit)  w_state_nxt = ST_IDLE;
    else if (cfg.cfg_en) w_state_nxt = ST_SHIFT;
  end

  always_comb begin
    cfg.cfg_busy = (r_state == ST_SHIFT);
  end

  // Commit wins over shift: it sees the pre-shift count and that cycle's din is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg.cfg_commit) begin
        r_cnt <= '0;
        if (r_cnt == CNT_FULL) begin
          r_active <= r_shadow;
          r_done   <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end else if (cfg.cfg_en) begin
        r_shadow <= {cfg.cfg_din, r_shadow[L-1:1]};
        if (r_state == ST_IDLE) begin
          r_cnt <= CNT_ONE;
          r_err <= 1'b0;
        end else if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign cfg.cfg_done = r_done;
  assign cfg.cfg_err  = r_err;
`ifdef SWBOX_READBACK_EN
  assign cfg.cfg_dout = r_shadow[0];
`endif

  // Pin p uses active bits [p*WW +: WW]; pins run top, bottom, left, right from bit 0.
  for (genvar p = 0; p < NPIN; p++) begin : g_pin
    swbox_pin_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW)) u_mux (
      .i_word    (r_active[p*WW +: WW]),
      .i_top     (top_in),
      .i_bottom  (bottom_in),
      .i_left    (left_in),
      .i_right   (right_in),
      .o_out     (w_out[p]),
      .o_oe      (w_oe[p]),
      .o_invalid (w_inv[p])
    );
  end

  assign cfg.bad_cfg = |w_inv;

  assign top_out    = w_out[NTB-1:0];
  assign top_oe     = w_oe[NTB-1:0];
  assign bottom_out = w_out[2*NTB-1:NTB];
  assign bottom_oe  = w_oe[2*NTB-1:NTB];
  assign left_out   = w_out[2*NTB+NLR-1:2*NTB];
  assign left_oe    = w_oe[2*NTB+NLR-1:2*NTB];
  assign right_out  = w_out[NPIN-1:2*NTB+NLR];
  assign right_oe   = w_oe[NPIN-1:2*NTB+NLR];

endmodule

// File: tb/tb_switch_box_cfg.sv
// Randomized self-checking bench for switch_box_cfg against a bit-history / word-table
// reference model. Define SWBOX_READBACK_EN to also exercise cfg_dout readback.
module tb_switch_box_cfg;

  localparam int NTB  = 5;
  localparam int NLR  = 4;
  localparam int IDXW = 3;
  localparam int NPIN = 2 * NTB + 2 * NLR;
  localparam int WW   = 3 + IDXW;
  localparam int L    = NPIN * WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NTB-1:0] top_in, bottom_in, top_out, top_oe, bottom_out, bottom_oe;
  logic [NLR-1:0] left_in, right_in, left_out, left_oe, right_out, right_oe;

  switch_box_cfg_if cfg ();

  switch_box_cfg #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .top_in     (top_in),
    .bottom_in  (bottom_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .top_out    (top_out),
    .top_oe     (top_oe),
    .bottom_out (bottom_out),
    .bottom_oe  (bottom_oe),
    .left_out   (left_out),
    .left_oe    (left_oe),
    .right_out  (right_out),
    .right_oe   (right_oe),
    .cfg        (cfg)
  );

  always #5 clk = ~clk;

  wire [NPIN-1:0] dut_out = {right_out, left_out, bottom_out, top_out};
  wire [NPIN-1:0] dut_oe  = {right_oe, left_oe, bottom_oe, top_oe};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: history of shifted bits, active image, count, flags.
  bit           m_hist[$];
  logic [L-1:0] m_active;
  int           m_cnt;
  bit           m_busy, m_err, m_done;
  logic [NPIN-1:0] e_out, e_oe;
  logic            e_bad;

  task automatic model_reset();
    m_hist.delete();
    m_active = '0;
    m_cnt = 0;
    m_busy = 0;
    m_err = 0;
    m_done = 0;
  endtask

  // Shadow = the last L bits sent; the earliest of them sits lowest.
  function automatic logic [L-1:0] shadow_img();
    logic [L-1:0] s = '0;
    int off = L - m_hist.size();
    for (int i = 0; i < m_hist.size(); i++) s[off + i] = m_hist[i];
    return s;
  endfunction

  task automatic model_edge(input bit en, input bit din, input bit commit);
    m_done = 0;
    if (commit) begin
      if (m_cnt == L) begin
        m_active = shadow_img();
        m_done = 1;
      end else begin
        m_err = 1;
      end
      m_cnt = 0;
      m_busy = 0;
    end else if (en) begin
      m_hist.push_back(din);
      if (m_hist.size() > L) void'(m_hist.pop_front());
      if (!m_busy) begin
        m_busy = 1;
        m_err = 0;
        m_cnt = 1;
      end else if (m_cnt < L + 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic model_route();
    int side, idx, width;
    logic [WW-1:0] w;
    e_out = '0;
    e_oe = '0;
    e_bad = 1'b0;
    for (int p = 0; p < NPIN; p++) begin
      w = m_active[p*WW +: WW];
      side = int'(w[2:0]);
      idx = int'(w[WW-1:3]);
      width = (side == 1 || side == 3) ? NTB : (side == 2 || side == 4) ? NLR : 0;
      if (side >= 5 || (side != 0 && idx >= width)) begin
        e_bad = 1'b1;
      end else if (side != 0) begin
        e_oe[p] = 1'b1;
        case (side)
          1: e_out[p] = top_in[idx];
          2: e_out[p] = right_in[idx];
          3: e_out[p] = bottom_in[idx];
          default: e_out[p] = left_in[idx];
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit din, input bit commit);
    cfg.cfg_en = en;
    cfg.cfg_din = din;
    cfg.cfg_commit = commit;
    tick();
    model_edge(en, din, commit);
    cfg.cfg_en = 1'b0;
    cfg.cfg_commit = 1'b0;
  endtask

  task automatic rand_inputs();
    top_in = 5'($urandom);
    bottom_in = 5'($urandom);
    left_in = 4'($urandom);
    right_in = 4'($urandom);
    #1;
  endtask

  function automatic logic [WW-1:0] mkw(input int idx, input int side);
    return {3'(idx), 3'(side)};
  endfunction

  function automatic logic [L-1:0] rand_img(input bit valid_only);
    logic [L-1:0] img = '0;
    int side;
    for (int p = 0; p < NPIN; p++) begin
      if (valid_only) begin
        side = $urandom_range(4, 1);
        img[p*WW +: WW] = mkw($urandom_range((side == 1 || side == 3) ? NTB - 1 : NLR - 1), side);
      end else begin
        img[p*WW +: WW] = WW'($urandom);
      end
    end
    return img;
  endfunction

  // Sends n bits LSB-first; beyond L the extra bits are random. Optional idle gaps.
  task automatic shift_bits(input logic [L-1:0] img, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, (i < L) ? img[i] : 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg.cfg_en = 1'b1;
    cfg.cfg_din = 1'b1;
    cfg.cfg_commit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tick();
      n_assert++;
      if ({dut_out, dut_oe, cfg.bad_cfg, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got out=%h oe=%h bad=%b busy=%b done=%b err=%b, expected all 0",
                 dut_out, dut_oe, cfg.bad_cfg, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err);
      end
    end
    cfg.cfg_en = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_route();
    logic [L-1:0] img = '0;
    img[0 +: WW] = mkw(2, 4);
    shift_bits(img, L, 1'b0);
    n_assert++;
    if (cfg.cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 1", cfg.cfg_busy);
    end
    drive(1'b0, 1'b0, 1'b1);
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_commit: got done/err/busy=%b expected 100",
               {cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy});
    end
    for (int k = 0; k < 4; k++) begin
      rand_inputs();
      left_in[2] = k[0];
      #1;
      n_assert++;
      if (top_oe !== 5'b00001 || top_out[0] !== k[0] || {bottom_oe, left_oe, right_oe} !== '0 ||
          {top_out[4:1], bottom_out, left_out, right_out} !== '0) begin
        n_fail++;
        $display("FAIL basic_route: got top_oe=%b top_out=%b other_oe=%h, expected 00001 with out[0]=%0d",
                 top_oe, top_out, {bottom_oe, left_oe, right_oe}, k[0]);
      end
    end
    tick();
    n_assert++;
    if (cfg.cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got %b expected 0", cfg.cfg_done);
    end
  endtask

  task automatic test_short_load();
    shift_bits(rand_img(1'b0), L - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    rand_inputs();
    model_route();
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err} !== 2'b01 || {dut_out, dut_oe, cfg.bad_cfg} !== {e_out, e_oe, e_bad}) begin
      n_fail++;
      $display("FAIL short_load: got done/err=%b out=%h oe=%h, expected 01 out=%h oe=%h",
               {cfg.cfg_done, cfg.cfg_err}, dut_out, dut_oe, e_out, e_oe);
    end
    drive(1'b1, 1'b1, 1'b0);
    n_assert++;
    if ({cfg.cfg_err, cfg.cfg_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL short_err_clear: got err/busy=%b expected 01", {cfg.cfg_err, cfg.cfg_busy});
    end
    drive(1'b0, 1'b0, 1'b1);
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err} !== {m_done, m_err}) begin
      n_fail++;
      $display("FAIL short_recommit: got done/err=%b expected %b", {cfg.cfg_done, cfg.cfg_err}, {m_done, m_err});
    end
  endtask

  task automatic test_invalid_index();
    logic [L-1:0] img = '0;
    img[(2*NTB+NLR+3)*WW +: WW] = mkw(5, 2);
    shift_bits(img, L, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    rand_inputs();
    n_assert++;
    if (right_oe[3] !== 1'b0 || cfg.bad_cfg !== 1'b1 || cfg.cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_idx: got right_oe[3]=%b bad=%b done=%b, expected 0 1 1",
               right_oe[3], cfg.bad_cfg, cfg.cfg_done);
    end
    img[(2*NTB+NLR+3)*WW +: WW] = mkw(1, 3);
    shift_bits(img, L, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      n_assert++;
      if (cfg.bad_cfg !== 1'b0 || right_oe[3] !== 1'b1 || right_out[3] !== bottom_in[1]) begin
        n_fail++;
        $display("FAIL invalid_reload: got bad=%b right_oe[3]=%b right_out[3]=%b, expected 0 1 %b",
                 cfg.bad_cfg, right_oe[3], right_out[3], bottom_in[1]);
      end
    end
  endtask

  task automatic test_simultaneous();
    shift_bits(rand_img(1'b1), L, 1'b0);
    cfg.cfg_en = 1'b1;
    cfg.cfg_din = 1'($urandom);
    cfg.cfg_commit = 1'b1;
    tick();
    model_edge(1'b1, cfg.cfg_din, 1'b1);
    cfg.cfg_en = 1'b0;
    cfg.cfg_commit = 1'b0;
    rand_inputs();
    model_route();
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy} !== 3'b100 ||
        {dut_out, dut_oe, cfg.bad_cfg} !== {e_out, e_oe, e_bad}) begin
      n_fail++;
      $display("FAIL simul_commit: got done/err/busy=%b out=%h oe=%h, expected 100 out=%h oe=%h",
               {cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy}, dut_out, dut_oe, e_out, e_oe);
    end
    drive(1'b0, 1'b0, 1'b1);
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL recommit_no_shift: got done/err=%b expected 01", {cfg.cfg_done, cfg.cfg_err});
    end
  endtask

  task automatic test_reset_mid_shift();
    shift_bits(rand_img(1'b1), 40, 1'b0);
    cfg.cfg_en = 1'b1;
    cfg.cfg_din = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({dut_out, dut_oe, cfg.bad_cfg, cfg.cfg_busy, cfg.cfg_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: got out=%h oe=%h bad=%b busy=%b err=%b, expected all 0",
               dut_out, dut_oe, cfg.bad_cfg, cfg.cfg_busy, cfg.cfg_err);
    end
    cfg.cfg_en = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b1);
    n_assert++;
    if ({cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_count_clear: got done/err/busy=%b expected 010",
               {cfg.cfg_done, cfg.cfg_err, cfg.cfg_busy});
    end
  endtask

  task automatic test_random();
    int lens[5] = '{L, L, L - 1, L + 1, L + 3};
    for (int it = 0; it < 8; it++) begin
      shift_bits(rand_img(1'b0), lens[$urandom_range(4)], 1'b1);
      n_assert++;
      if (cfg.cfg_busy !== m_busy) begin
        n_fail++;
        $display("FAIL rand_busy[%0d]: got %b expected %b", it, cfg.cfg_busy, m_busy);
      end
      drive(1'b0, 1'b0, 1'b1);
      n_assert++;
      if ({cfg.cfg_done, cfg.cfg_err} !== {m_done, m_err}) begin
        n_fail++;
        $display("FAIL rand_commit[%0d]: got done/err=%b expected %b", it,
                 {cfg.cfg_done, cfg.cfg_err}, {m_done, m_err});
      end
      for (int k = 0; k < 3; k++) begin
        rand_inputs();
        model_route();
        n_assert++;
        if ({dut_out, dut_oe, cfg.bad_cfg} !== {e_out, e_oe, e_bad}) begin
          n_fail++;
          $display("FAIL rand_route[%0d]: got out=%h oe=%h bad=%b, expected out=%h oe=%h bad=%b",
                   it, dut_out, dut_oe, cfg.bad_cfg, e_out, e_oe, e_bad);
        end
      end
    end
  endtask

`ifdef SWBOX_READBACK_EN
  task automatic test_readback();
    logic [L-1:0] img_a = rand_img(1'b0);
    logic [L-1:0] img_b = rand_img(1'b0);
    int errs = 0;
    shift_bits(img_a, L, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < L; i++) begin
      n_assert++;
      if (cfg.cfg_dout !== img_a[i]) begin
        n_fail++;
        errs++;
        if (errs < 5) $display("FAIL readback[%0d]: got %b expected %b", i, cfg.cfg_dout, img_a[i]);
      end
      drive(1'b1, img_b[i], 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    cfg.cfg_en = 1'b0;
    cfg.cfg_din = 1'b0;
    cfg.cfg_commit = 1'b0;
    top_in = '0;
    bottom_in = '0;
    left_in = '0;
    right_in = '0;
    test_reset();
    test_basic_route();
    test_short_load();
    test_invalid_index();
    test_simultaneous();
    test_reset_mid_shift();
    test_random();
`ifdef SWBOX_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_box_cfg.md
# switch_box_cfg

Parametrised, serially configured routing switch box for the fabric interconnect. Each pin on each of the four sides (top, bottom, left, right) can be driven from any input pin on any side, or left undriven. Routing is held in an active configuration register that is loaded through a bit-serial shift chain into a shadow register and applied atomically on commit. Pads are split into separate in/out/oe signals at this level so that an arbitrary route can never form a combinational loop; tristate pads live in the tile wrapper.

## Interface
- NTB, 5: pins on the top side and on the bottom side (each)
- NLR, 4: pins on the left side and on the right side (each)
- IDXW, 3: index field width; must satisfy 2^IDXW ≥ max(NTB, NLR)
- Derived constants: NPIN = 2·NTB + 2·NLR; WW = 3 + IDXW (word width); L = NPIN·WW (chain length; 108 at defaults)
- clk  in  1  configuration clock
- rst_n  in  1  asynchronous active-low reset
- top_in, bottom_in  in  NTB  pad inputs
- left_in, right_in  in  NLR  pad inputs
- top_out/top_oe, bottom_out/bottom_oe  out  NTB each  routed value and drive enable
- left_out/left_oe, right_out/right_oe  out  NLR each  routed value and drive enable
- cfg_en  in  1  shift enable; cfg_din is sampled on each clk edge while high
- cfg_din  in  1  serial config bit
- cfg_commit  in  1  single-cycle request to apply the shadow register
- cfg_busy  out  1  high while in SHIFT
- cfg_done  out  1  one-cycle pulse after a successful commit
- cfg_err  out  1  sticky: commit rejected on bit-count mismatch
- bad_cfg  out  1  high while any active word is invalid

## Operation
- Word per pin = {idx[IDXW-1:0], side[2:0]}. Side codes: 0 = none, 1 = top, 2 = right, 3 = bottom, 4 = left, 5..7 = invalid.
- Routing (combinational from the active register): for a valid word, out = <side>_in[idx] and oe = 1. For none or invalid, out = 0 and oe = 0.
- A word is invalid if side ≥ 5, or if idx ≥ the width of the selected side (NTB for top/bottom, NLR for left/right).
- Chain order, MSB to LSB: right[NLR-1..0], left[NLR-1..0], bottom[NTB-1..0], top[NTB-1..0].
- Shift direction: cfg_din enters at bit L-1 and the register shifts right. The first bit sent lands in bit 0 (top[0] side bit 0), so words are sent LSB-first, top[0] first.
- FSM states:
  - IDLE: cfg_en high → SHIFT, clear the bit count, clear cfg_err, and shift in the first bit.
  - SHIFT: each cycle cfg_en is high, shift and increment the bit count. The count saturates at L+1.
  - cfg_commit in either state → IDLE.
    - If count == L: active ← shadow, bad_cfg recomputed from the new value, cfg_done pulses.
    - Otherwise: active unchanged, cfg_err ← 1.
    - In both cases the count clears.
- cfg_commit and cfg_en high in the same cycle: the commit is evaluated on the pre-shift count, and that cycle's cfg_din bit is discarded.
- cfg_en dropping without a commit: stay in SHIFT and hold the count. Shifting may resume later.
- The shadow register is never cleared by a commit. Re-committing without shifting raises cfg_err, because the count is 0.

## Timing
- Reset (asynchronous, on rst_n low): shadow, active, count, cfg_err, cfg_done, bad_cfg all 0; state IDLE.
  - All *_oe = 0 and all *_out = 0 immediately.
- Route latency: combinational from *_in to *_out. A new route is visible in the cycle after the commit edge.
- cfg_done is high for exactly the one cycle following the commit edge.
- cfg_err sets on the rejecting commit edge and clears on the next IDLE→SHIFT transition or on reset.
- Reset mid-shift or mid-commit discards the partial shadow contents. The active register clears as well.

## Configuration
- SWBOX_READBACK_EN defined:
  - Adds output cfg_dout (1 bit), equal to shadow bit 0. Each shift moves the old contents out.
  - Shifting L bits therefore reads back the previous shadow image, LSB-first.
- SWBOX_READBACK_EN undefined: cfg_dout is not present, and the logic is otherwise identical.

## Structure
- Package swbox_pkg holds:
  - side-code localparams (SIDE_NONE, SIDE_TOP, SIDE_RIGHT, SIDE_BOTTOM, SIDE_LEFT);
  - the FSM state enum;
  - a function word_valid(side, idx, NTB, NLR).
- Sub-module swbox_pin_mux: one word plus the four side input vectors in, out/oe/invalid out. It is instantiated NPIN times in generate loops.

## Test plan
- Reset: assert rst_n low with random inputs → all oe = 0, out = 0, bad_cfg = 0, cfg_busy = 0.
- Basic route (defaults): shift 108 bits with top[0] = {idx 2, side 4} and all other words 0, then commit.
  - cfg_done pulses; top_oe = 5'b00001 and top_out[0] follows left_in[2] while left_in[2] toggles; all other oe = 0.
- Short load: shift 107 bits, then commit → cfg_err = 1, cfg_done = 0, active routes unchanged.
  - The next cfg_en clears cfg_err.
- Invalid index: right[3] = {idx 5, side 2} (5 ≥ NLR), committed → right_oe[3] = 0 and bad_cfg = 1.
  - Reloading right[3] = {idx 1, side 3} → bad_cfg = 0 and right_out[3] = bottom_in[1].
- Simultaneous events: commit in the same cycle as the 109th shift bit, after exactly 108 bits → commit succeeds and the 109th bit is discarded.
  - Also: pulse rst_n low mid-shift → all routes off, state IDLE.
- Readback (with SWBOX_READBACK_EN): load image A, then shift image B → cfg_dout emits image A LSB-first, bit-exact.
